rvfpm_spec_queue: RTL and testbench

RVFPM_SPEC_QUEUE -- requirements
Module: rvfpm_spec_queue

---
 rtl/rvfpm_spec_queue_pkg.sv | 26 ++
 rtl/rvfpm_spec_queue_oldest_match.sv | 41 ++++
 rtl/rvfpm_spec_queue.sv | 182 ++++++++++++++++++
 tb/tb_rvfpm_spec_queue.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvfpm_spec_queue_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pa_rvfpm
// Description : Shared constants and the speculative-queue entry type.
// Revision    : 1.0 - initial release
// ============================================================================
package pa_rvfpm;

    localparam int c_DEFAULT_DEPTH     = 4;
    // Entry fields are sized for the widest supported configuration;
    // narrower instances zero-extend on write and truncate on read.
    localparam int c_MAX_FLEN          = 64;
    localparam int c_MAX_X_ID_WIDTH    = 16;

    typedef struct packed {
        logic                        valid;
        logic                        committed;
        logic [31:0]                 instr;
        logic [c_MAX_X_ID_WIDTH-1:0] id;
        logic [c_MAX_FLEN-1:0]       rs_a;
        logic [c_MAX_FLEN-1:0]       rs_b;
        logic [c_MAX_FLEN-1:0]       rs_c;
    } spec_entry_t;

endpackage
`default_nettype wire

// File: rtl/rvfpm_spec_queue_oldest_match.sv
`default_nettype none
// ============================================================================
// Module      : rvfpm_oldest_match
// Description : Finds the oldest valid, uncommitted entry carrying commit_id.
// Revision    : 1.0 - initial release
// ============================================================================
module rvfpm_oldest_match
    import pa_rvfpm::*;
#(
    parameter int DEPTH      = c_DEFAULT_DEPTH,
    parameter int X_ID_WIDTH = 4,
    localparam int IW        = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]            i_valid,
    input  logic [DEPTH-1:0]            i_committed,
    input  logic [DEPTH*X_ID_WIDTH-1:0] i_id,
    input  logic [IW-1:0]               i_head,
    input  logic [X_ID_WIDTH-1:0]       i_commit_id,
    output logic                        o_hit,
    output logic [IW-1:0]               o_index
);

    logic [IW-1:0] w_idx;

    // Walk from youngest to oldest so the oldest candidate is the last writer.
    always_comb begin
        o_hit   = 1'b0;
        o_index = '0;
        w_idx   = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            w_idx = i_head + IW'(k);
            if (i_valid[w_idx] && !i_committed[w_idx] &&
                (i_id[w_idx*X_ID_WIDTH +: X_ID_WIDTH] == i_commit_id)) begin
                o_hit   = 1'b1;
                o_index = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rvfpm_spec_queue.sv
`default_nettype none
// ============================================================================
// Module      : rvfpm_spec_queue
// Description : FIFO of speculative FP instructions released by XIF commit.
//               Define RVFPM_QUEUE_LEVEL_EN to add level/almost_full outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module rvfpm_spec_queue
    import pa_rvfpm::*;
#(
    parameter int DEPTH      = c_DEFAULT_DEPTH,
    parameter int X_ID_WIDTH = 4,
    parameter int FLEN       = 32
) (
    input  logic                         ck,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_instr,
    input  logic [X_ID_WIDTH-1:0]        in_id,
    input  logic [FLEN-1:0]              in_rs_a,
    input  logic [FLEN-1:0]              in_rs_b,
    input  logic [FLEN-1:0]              in_rs_c,
    input  logic                         commit_valid,
    input  logic [X_ID_WIDTH-1:0]        commit_id,
    input  logic                         commit_kill,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_instr,
    output logic [X_ID_WIDTH-1:0]        out_id,
    output logic [FLEN-1:0]              out_rs_a,
    output logic [FLEN-1:0]              out_rs_b,
    output logic [FLEN-1:0]              out_rs_c,
`ifdef RVFPM_QUEUE_LEVEL_EN
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         almost_full,
`endif
    output logic                         commit_miss
);

    localparam int c_IW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH + 1);

    spec_entry_t                 r_mem [DEPTH];
    logic [c_IW-1:0]             r_head;
    logic [c_IW-1:0]             r_tail;
    logic [c_CW-1:0]             r_count;
    logic                        r_miss;

    logic [DEPTH-1:0]            w_valid;
    logic [DEPTH-1:0]            w_committed;
    logic [DEPTH*X_ID_WIDTH-1:0] w_id;
    logic                        w_hit;
    logic [c_IW-1:0]             w_hit_idx;
    logic [c_IW-1:0]             w_kill_rel;
    logic                        w_full;
    logic                        w_kill;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_commit_hit;
    logic                        w_push_commit;
    logic                        w_miss_next;
    spec_entry_t                 w_new;

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign w_valid[g]                              = r_mem[g].valid;
        assign w_committed[g]                          = r_mem[g].committed;
        assign w_id[g*X_ID_WIDTH +: X_ID_WIDTH]        = X_ID_WIDTH'(r_mem[g].id);
    end

    rvfpm_oldest_match #(
        .DEPTH      (DEPTH),
        .X_ID_WIDTH (X_ID_WIDTH)
    ) u_match (
        .i_valid     (w_valid),
        .i_committed (w_committed),
        .i_id        (w_id),
        .i_head      (r_head),
        .i_commit_id (commit_id),
        .o_hit       (w_hit),
        .o_index     (w_hit_idx)
    );

    assign w_full     = (r_count == c_CW'(DEPTH));
    assign w_kill     = commit_valid && commit_kill;
    assign in_ready   = !w_full && !w_kill;
    assign w_push     = in_valid && in_ready;
    assign out_valid  = r_mem[r_head].valid && r_mem[r_head].committed;
    assign w_pop      = out_valid && out_ready;
    assign w_kill_rel = w_hit_idx - r_head;

    // A same-cycle push is younger than every stored entry, so it only
    // takes the commit when nothing already queued matched.
    assign w_commit_hit  = commit_valid && w_hit;
    assign w_push_commit = commit_valid && !commit_kill && !w_hit && w_push &&
                           (in_id == commit_id);
    assign w_miss_next   = commit_valid && !w_hit && !w_push_commit;

    always_comb begin
        w_new           = '0;
        w_new.valid     = 1'b1;
        w_new.committed = w_push_commit;
        w_new.instr     = in_instr;
        w_new.id        = c_MAX_X_ID_WIDTH'(in_id);
        w_new.rs_a      = c_MAX_FLEN'(in_rs_a);
        w_new.rs_b      = c_MAX_FLEN'(in_rs_b);
        w_new.rs_c      = c_MAX_FLEN'(in_rs_c);
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_miss  <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i].valid     <= 1'b0;
                r_mem[i].committed <= 1'b0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_miss  <= 1'b0;
        end else begin
            r_miss <= w_miss_next;
            if (w_pop) begin
                r_mem[r_head].valid     <= 1'b0;
                r_mem[r_head].committed <= 1'b0;
                r_head                  <= r_head + c_IW'(1);
            end
            if (w_commit_hit && !commit_kill) begin
                r_mem[w_hit_idx].committed <= 1'b1;
            end
            if (w_commit_hit && commit_kill) begin
                // Drop the matched entry and everything pushed after it.
                for (int i = 0; i < DEPTH; i++) begin
                    if ((c_IW'(i) - r_head) >= w_kill_rel) begin
                        r_mem[i].valid     <= 1'b0;
                        r_mem[i].committed <= 1'b0;
                    end
                end
                r_tail  <= w_hit_idx;
                r_count <= c_CW'(w_kill_rel) - c_CW'(w_pop);
            end else begin
                if (w_push) begin
                    r_mem[r_tail] <= w_new;
                    r_tail        <= r_tail + c_IW'(1);
                end
                r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
            end
        end
    end

    always_comb begin
        out_instr = '0;
        out_id    = '0;
        out_rs_a  = '0;
        out_rs_b  = '0;
        out_rs_c  = '0;
        if (r_mem[r_head].valid) begin
            out_instr = r_mem[r_head].instr;
            out_id    = X_ID_WIDTH'(r_mem[r_head].id);
            out_rs_a  = FLEN'(r_mem[r_head].rs_a);
            out_rs_b  = FLEN'(r_mem[r_head].rs_b);
            out_rs_c  = FLEN'(r_mem[r_head].rs_c);
        end
    end

    assign commit_miss = r_miss;

`ifdef RVFPM_QUEUE_LEVEL_EN
    assign level       = r_count;
    assign almost_full = (r_count >= c_CW'(DEPTH - 1));
`endif

endmodule
`default_nettype wire

// File: tb/tb_rvfpm_spec_queue.sv
`default_nettype none
`timescale 1ns/1ps
// Directed self-checking bench for rvfpm_spec_queue (DEPTH=4, 4-bit ids).
module tb_rvfpm_spec_queue;

    localparam int XW = 4;
    localparam int FL = 32;

    logic          ck = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_instr;
    logic [XW-1:0] in_id;
    logic [FL-1:0] in_rs_a, in_rs_b, in_rs_c;
    logic          commit_valid;
    logic [XW-1:0] commit_id;
    logic          commit_kill;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [XW-1:0] out_id;
    logic [FL-1:0] out_rs_a, out_rs_b, out_rs_c;
    logic          commit_miss;
`ifdef RVFPM_QUEUE_LEVEL_EN
    logic [2:0]    level;
    logic          almost_full;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 ck = ~ck;

    rvfpm_spec_queue dut (
        .ck           (ck),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_id        (in_id),
        .in_rs_a      (in_rs_a),
        .in_rs_b      (in_rs_b),
        .in_rs_c      (in_rs_c),
        .commit_valid (commit_valid),
        .commit_id    (commit_id),
        .commit_kill  (commit_kill),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_id       (out_id),
        .out_rs_a     (out_rs_a),
        .out_rs_b     (out_rs_b),
        .out_rs_c     (out_rs_c),
`ifdef RVFPM_QUEUE_LEVEL_EN
        .level        (level),
        .almost_full  (almost_full),
`endif
        .commit_miss  (commit_miss)
    );

    task automatic idle();
        in_valid     = 1'b0;
        flush        = 1'b0;
        commit_valid = 1'b0;
        commit_kill  = 1'b0;
        out_ready    = 1'b0;
    endtask

    task automatic cyc();
        @(posedge ck);
        #1;
    endtask

    task automatic smp();
        @(negedge ck);
    endtask

    task automatic push_set(input logic [XW-1:0] id);
        in_valid = 1'b1;
        in_id    = id;
        in_instr = 32'h0000_1000 + 32'(id);
        in_rs_a  = 32'hA000_0000 + 32'(id);
        in_rs_b  = 32'hB000_0000 + 32'(id);
        in_rs_c  = 32'hC000_0000 + 32'(id);
    endtask

    task automatic do_flush();
        idle();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        in_id = '0; in_instr = '0; in_rs_a = '0; in_rs_b = '0; in_rs_c = '0;
        commit_id = '0;
        repeat (2) cyc();
        smp();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (commit_miss !== 1'b0) begin failures++; $display("FAIL reset_commit_miss got=%b exp=0", commit_miss); end
        checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL reset_out_instr got=%h exp=0", out_instr); end
        checks++; if (dut.r_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", dut.r_count); end
        cyc();
        rst = 1'b1;
        smp();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        cyc();
    endtask

    task automatic test_in_order();
        for (int k = 1; k <= 3; k++) begin
            push_set(XW'(k));
            cyc();
        end
        idle();
        commit_valid = 1'b1; commit_id = 4'd1; out_ready = 1'b1;
        smp();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL order_no_fallthrough got=%b exp=0", out_valid); end
        cyc();
        commit_id = 4'd2;
        smp();
        checks++; if (out_valid !== 1'b1 || out_id !== 4'd1) begin failures++; $display("FAIL order_first got=%b/%0d exp=1/1", out_valid, out_id); end
        checks++; if (out_rs_a !== 32'hA000_0001 || out_rs_c !== 32'hC000_0001 || out_instr !== 32'h1001) begin failures++; $display("FAIL order_first_data got=%h/%h/%h", out_rs_a, out_rs_c, out_instr); end
        cyc();
        commit_id = 4'd3;
        smp();
        checks++; if (out_valid !== 1'b1 || out_id !== 4'd2) begin failures++; $display("FAIL order_second got=%b/%0d exp=1/2", out_valid, out_id); end
        cyc();
        commit_valid = 1'b0;
        smp();
        checks++; if (out_valid !== 1'b1 || out_id !== 4'd3 || out_rs_b !== 32'hB000_0003) begin failures++; $display("FAIL order_third got=%b/%0d/%h exp=1/3/b0000003", out_valid, out_id, out_rs_b); end
        cyc();
        smp();
        checks++; if (out_valid !== 1'b0 || out_id !== 4'd0 || dut.r_count !== 3'd0) begin failures++; $display("FAIL order_drained got=%b/%0d/%0d exp=0/0/0", out_valid, out_id, dut.r_count); end
        cyc();
        idle();
    endtask

    task automatic test_full_wrap();
        logic [XW-1:0] exp_ids [4];
        logic [XW-1:0] got [$];
        exp_ids = '{4'd2, 4'd3, 4'd4, 4'd5};
        do_flush();
        for (int k = 1; k <= 4; k++) begin
            push_set(XW'(k));
            cyc();
        end
        push_set(4'd5);
        commit_valid = 1'b1; commit_id = 4'd1;
        smp();
        checks++; if (in_ready !== 1'b0 || dut.r_count !== 3'd4 || dut.r_tail !== 2'd0) begin failures++; $display("FAIL full_state got=%b/%0d/%0d exp=0/4/0", in_ready, dut.r_count, dut.r_tail); end
`ifdef RVFPM_QUEUE_LEVEL_EN
        checks++; if (level !== 3'd4 || almost_full !== 1'b1) begin failures++; $display("FAIL full_level got=%0d/%b exp=4/1", level, almost_full); end
`endif
        cyc();
        commit_valid = 1'b0; out_ready = 1'b1;
        smp();
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL full_pop_push got=%b/%b exp=1/0", out_valid, in_ready); end
        cyc();
        out_ready = 1'b0;
        smp();
        checks++; if (in_ready !== 1'b1 || dut.r_count !== 3'd3) begin failures++; $display("FAIL after_pop got=%b/%0d exp=1/3", in_ready, dut.r_count); end
        cyc();
        in_valid = 1'b0;
        smp();
        checks++; if (dut.r_tail !== 2'd1 || dut.r_count !== 3'd4) begin failures++; $display("FAIL wrap_push got=%0d/%0d exp=1/4", dut.r_tail, dut.r_count); end
        for (int c = 0; c < 10; c++) begin
            commit_valid = (c < 4);
            commit_id    = (c < 4) ? exp_ids[c] : 4'd0;
            out_ready    = 1'b1;
            smp();
            if (out_valid) got.push_back(out_id);
            cyc();
        end
        idle();
        checks++; if (got.size() !== 4) begin failures++; $display("FAIL wrap_dispatch_count got=%0d exp=4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            checks++; if (got[i] !== exp_ids[i]) begin failures++; $display("FAIL wrap_dispatch_%0d got=%0d exp=%0d", i, got[i], exp_ids[i]); end
        end
    endtask

    task automatic test_kill();
        do_flush();
        for (int k = 1; k <= 4; k++) begin
            push_set(XW'(k));
            cyc();
        end
        idle();
        commit_valid = 1'b1; commit_id = 4'd1;
        cyc();
        commit_id = 4'd2; commit_kill = 1'b1;
        smp();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL kill_in_ready got=%b exp=0", in_ready); end
        cyc();
        idle();
        smp();
        checks++; if (dut.r_count !== 3'd1 || dut.r_tail !== 2'd1) begin failures++; $display("FAIL kill_state got=%0d/%0d exp=1/1", dut.r_count, dut.r_tail); end
        checks++; if (out_valid !== 1'b1 || out_id !== 4'd1 || commit_miss !== 1'b0) begin failures++; $display("FAIL kill_head got=%b/%0d/%b exp=1/1/0", out_valid, out_id, commit_miss); end
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        commit_valid = 1'b1; commit_id = 4'd3;
        smp();
        checks++; if (out_valid !== 1'b0 || dut.r_count !== 3'd0) begin failures++; $display("FAIL kill_drained got=%b/%0d exp=0/0", out_valid, dut.r_count); end
        cyc();
        idle();
        smp();
        checks++; if (commit_miss !== 1'b1) begin failures++; $display("FAIL killed_id_gone got=%b exp=1", commit_miss); end
        cyc();
    endtask

    task automatic test_miss();
        do_flush();
        push_set(4'd3);
        cyc();
        idle();
        commit_valid = 1'b1; commit_id = 4'd7;
        cyc();
        commit_valid = 1'b0;
        smp();
        checks++; if (commit_miss !== 1'b1 || dut.r_count !== 3'd1) begin failures++; $display("FAIL miss_pulse got=%b/%0d exp=1/1", commit_miss, dut.r_count); end
        cyc();
        smp();
        checks++; if (commit_miss !== 1'b0) begin failures++; $display("FAIL miss_one_cycle got=%b exp=0", commit_miss); end
        commit_valid = 1'b1; commit_id = 4'd3;
        cyc();
        smp();
        checks++; if (commit_miss !== 1'b0) begin failures++; $display("FAIL miss_first_commit got=%b exp=0", commit_miss); end
        cyc();
        idle();
        smp();
        checks++; if (commit_miss !== 1'b1) begin failures++; $display("FAIL miss_recommit got=%b exp=1", commit_miss); end
        flush = 1'b1; commit_valid = 1'b1; commit_id = 4'd9;
        cyc();
        idle();
        smp();
        checks++; if (commit_miss !== 1'b0 || dut.r_count !== 3'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL flush_priority got=%b/%0d/%b exp=0/0/0", commit_miss, dut.r_count, out_valid); end
        commit_valid = 1'b1; commit_id = 4'd9;
        cyc();
        idle();
        smp();
        checks++; if (commit_miss !== 1'b1) begin failures++; $display("FAIL miss_empty got=%b exp=1", commit_miss); end
        cyc();
    endtask

    task automatic test_same_cycle();
        do_flush();
        push_set(4'd5);
        commit_valid = 1'b1; commit_id = 4'd5;
        smp();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL same_no_fallthrough got=%b exp=0", out_valid); end
        cyc();
        idle();
        smp();
        checks++; if (out_valid !== 1'b1 || out_id !== 4'd5 || commit_miss !== 1'b0) begin failures++; $display("FAIL same_commit got=%b/%0d/%b exp=1/5/0", out_valid, out_id, commit_miss); end
        out_ready = 1'b1;
        push_set(4'd6); in_rs_a = 32'h0000_AAAA;
        cyc();
        out_ready = 1'b0;
        push_set(4'd6); in_rs_a = 32'h0000_BBBB;
        smp();
        checks++; if (dut.r_count !== 3'd1) begin failures++; $display("FAIL push_pop_count got=%0d exp=1", dut.r_count); end
        cyc();
        idle();
        commit_valid = 1'b1; commit_id = 4'd6;
        cyc();
        idle();
        out_ready = 1'b1;
        smp();
        checks++; if (out_valid !== 1'b1 || out_rs_a !== 32'h0000_AAAA || dut.r_count !== 3'd2) begin failures++; $display("FAIL dup_older got=%b/%h/%0d exp=1/0000aaaa/2", out_valid, out_rs_a, dut.r_count); end
        cyc();
        out_ready = 1'b0;
        smp();
        checks++; if (out_valid !== 1'b0 || out_id !== 4'd6 || out_rs_a !== 32'h0000_BBBB) begin failures++; $display("FAIL dup_younger got=%b/%0d/%h exp=0/6/0000bbbb", out_valid, out_id, out_rs_a); end
        cyc();
    endtask

    task automatic test_pop_kill();
        do_flush();
        for (int k = 1; k <= 3; k++) begin
            push_set(XW'(k));
            cyc();
        end
        idle();
        commit_valid = 1'b1; commit_id = 4'd1;
        cyc();
        commit_id = 4'd2; commit_kill = 1'b1; out_ready = 1'b1;
        cyc();
        idle();
        smp();
        checks++; if (dut.r_count !== 3'd0 || out_valid !== 1'b0 || dut.r_head !== 2'd1 || dut.r_tail !== 2'd1) begin failures++; $display("FAIL pop_kill got=%0d/%b/%0d/%0d exp=0/0/1/1", dut.r_count, out_valid, dut.r_head, dut.r_tail); end
        cyc();
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        do_flush();
        for (int k = 1; k <= 3; k++) begin
            push_set(XW'(k));
            cyc();
        end
        idle();
        commit_valid = 1'b1; commit_id = 4'd1;
        cyc();
        idle();
        smp();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rstmid_pre got=%b exp=1", out_valid); end
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_id !== 4'd0 || dut.r_count !== 3'd0) begin failures++; $display("FAIL rstmid_immediate got=%b/%0d/%0d exp=0/0/0", out_valid, out_id, dut.r_count); end
`ifdef RVFPM_QUEUE_LEVEL_EN
        checks++; if (level !== 3'd0 || almost_full !== 1'b0) begin failures++; $display("FAIL rstmid_level got=%0d/%b exp=0/0", level, almost_full); end
`endif
        cyc();
        rst = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            smp();
            if (out_valid) seen++;
            cyc();
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL rstmid_no_dispatch got=%0d exp=0", seen); end
        push_set(4'd8);
        commit_valid = 1'b1; commit_id = 4'd8;
        cyc();
        idle();
        smp();
        checks++; if (out_valid !== 1'b1 || out_id !== 4'd8) begin failures++; $display("FAIL rstmid_recover got=%b/%0d exp=1/8", out_valid, out_id); end
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_in_order();
        test_full_wrap();
        test_kill();
        test_miss();
        test_same_cycle();
        test_pop_kill();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
